// File: rtl/edge_detector_bank.sv
// Multi-channel edge detector: synchroniser, debounce filter, mode-selected
// one-cycle pulses, sticky write-1-to-clear pending flags and a combined irq.
module edge_detector_bank #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     inp,
    input  logic [2*N-1:0]   mode,
    input  logic [N-1:0]     clear,
    input  logic [N-1:0]     irq_en,
    output logic [N-1:0]     pulse,
    output logic [N-1:0]     level,
    output logic [N-1:0]     pending,
    output logic             irq
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q [N];
    logic [CW-1:0]          cnt [N];
    logic [CW-1:0]          cnt_next [N];
    logic [N-1:0]           s;
    logic [N-1:0]           st;
    logic [N-1:0]           st_next;
    logic [N-1:0]           pulse_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], inp[i]};
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            s[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    // A mismatch must persist DB_CYCLES consecutive cycles; any matching cycle restarts it.
    always_comb begin
        st_next    = st;
        pulse_next = '0;
        for (int i = 0; i < N; i++) begin
            cnt_next[i] = '0;
            if (s[i] != st[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    st_next[i] = s[i];
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
            pulse_next[i] = (~st[i] &  st_next[i] & mode[2*i])
                          | ( st[i] & ~st_next[i] & mode[2*i+1]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st      <= '0;
            pulse   <= '0;
            pending <= '0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            st      <= st_next;
            pulse   <= pulse_next;
            // A new event outranks a clear arriving on the same edge.
            pending <= (pending & ~clear) | pulse_next;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    assign level = st;
    assign irq   = |(pending & irq_en);

endmodule
